// File: rtl/dac_out_pkg.sv
// Shared types and constants for the DAC output stage.
package dac_out_pkg;

    // Prefill state machine: PRIME fills the FIFO, RUN streams to the DAC.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } dac_state_t;

    localparam int UNDERRUN_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (v == '1) ? v : v + UNDERRUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dac_out_stage_if.sv
// Sample input handshake of the DAC output stage.
// Handshake: a sample transfers on a rising clk edge where i_valid && o_ready;
// the master keeps i_data stable while i_valid is high and o_ready is low,
// and o_ready never depends on i_valid.
interface dac_out_stage_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy count and no fall-through:
// a word pushed on an edge is readable only from the following cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Qualify requests so the pointers can never overrun
    always_comb begin
        full    = (level == LVL_FULL);
        empty   = (level == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rd_data = mem[rd_ptr];
    end

    // Storage array, written at the write pointer
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally; level disambiguates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_out_stage.sv
// Output stage feeding an 8-bit video DAC: FIFO buffering, DAC clock divider,
// prefill FSM and underrun detection.
// Optional: define DAC_UNDERRUN_CNT_EN to add the saturating o_underrun_cnt port.
module dac_out_stage
    import dac_out_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    dac_out_stage_if.slave            bus,
    output logic [DATA_W-1:0]         o_dac,
    output logic                      o_dac_clk,
    output logic                      o_underrun,
    output logic [$clog2(DEPTH):0]    o_level,
    output dac_state_t                o_state
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0]     DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]     DIV_HALF = CW'(DIV / 2);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [LW-1:0]     LVL_HALF = LW'(DEPTH / 2);
    localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    dac_state_t        state;
    dac_state_t        state_next;
    logic [CW-1:0]     div_cnt;
    logic [CW-1:0]     div_next;
    logic              tick;
    logic              push;
    logic              pop;
    logic              starve;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .wr_data (bus.i_data),
        .pop     (pop),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // Ready comes from the registered level only, never from i_valid
    always_comb begin
        bus.o_ready = !full;
        push        = bus.i_valid && !full;
        o_level     = level;
        o_state     = state;
    end

    // Divider: a tick is the edge where div_cnt wraps from DIV-1 to 0
    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        div_next = tick ? '0 : div_cnt + CNT_ONE;
    end

    // Divider and DAC clock; the clock is low for the first DIV/2 cycles after a tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt   <= '0;
            o_dac_clk <= 1'b0;
        end else begin
            div_cnt   <= div_next;
            o_dac_clk <= (div_next >= DIV_HALF);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= PRIME;
        else          state <= state_next;
    end

    // FSM next state: leave PRIME once half full, counting this cycle's push
    always_comb begin
        state_next = state;
        if (state == PRIME && (level + (push ? LVL_ONE : '0)) >= LVL_HALF)
            state_next = RUN;
    end

    // FSM outputs: in RUN each tick either pops the head or reports starvation
    always_comb begin
        pop    = (state == RUN) && tick && !empty;
        starve = (state == RUN) && tick && empty;
    end

    // Output registers: DAC data holds its last value on an underrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dac      <= MIDSCALE;
            o_underrun <= 1'b0;
        end else begin
            if (pop) o_dac <= head;
            o_underrun <= starve;
        end
    end

`ifdef DAC_UNDERRUN_CNT_EN
    // Saturating count of empty ticks, advancing with each underrun pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    o_underrun_cnt <= '0;
        else if (starve) o_underrun_cnt <= sat_inc(o_underrun_cnt);
    end
`endif

endmodule

// File: tb/tb_dac_out_stage.sv
// Testbench for dac_out_stage (DATA_W=8, DEPTH=8, DIV=4).
// Honours DAC_UNDERRUN_CNT_EN when the design is built with it.
module tb_dac_out_stage;
    import dac_out_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int DIV    = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac_out_stage_if #(.DATA_W(DATA_W)) bus ();

    logic [DATA_W-1:0] o_dac;
    logic              o_dac_clk;
    logic              o_underrun;
    logic [3:0]        o_level;
    dac_state_t        o_state;
`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0]       o_underrun_cnt;
`endif

    dac_out_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .DIV    (DIV)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_dac          (o_dac),
        .o_dac_clk      (o_dac_clk),
        .o_underrun     (o_underrun),
        .o_level        (o_level),
        .o_state        (o_state)
`ifdef DAC_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (o_underrun_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of buffered samples; edges counted since reset release give DAC phase.
    logic [DATA_W-1:0] exp_q[$];
    bit                m_run;
    int                m_k;
    logic [DATA_W-1:0] m_dac;
    bit                m_uf;
    bit                m_dclk;
    int                m_cnt;

    task automatic model_reset();
        exp_q.delete();
        m_run  = 0;
        m_k    = 0;
        m_dac  = 8'h80;
        m_uf   = 0;
        m_dclk = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit tk;
        bit pu;
        m_k++;
        tk   = (m_k % DIV) == 0;
        pu   = bus.i_valid && (exp_q.size() != DEPTH);
        m_uf = 0;
        if (m_run && tk) begin
            if (exp_q.size() > 0) m_dac = exp_q.pop_front();
            else begin
                m_uf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        if (pu) exp_q.push_back(bus.i_data);
        if (!m_run && exp_q.size() >= DEPTH / 2) m_run = 1;
        m_dclk = (m_k % DIV) >= DIV / 2;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("dac",   o_dac, m_dac);
            check("dclk",  o_dac_clk, m_dclk);
            check("uflow", o_underrun, m_uf);
            check("level", o_level, exp_q.size());
            check("ready", bus.o_ready, exp_q.size() != DEPTH);
            check("state", o_state, m_run ? RUN : PRIME);
`ifdef DAC_UNDERRUN_CNT_EN
            check("ucnt",  o_underrun_cnt, m_cnt);
`endif
        end
    end

    // ---------------- DAC-side collector ----------------
    logic [DATA_W-1:0] dac_seen[$];
    int                uf_seen = 0;
    bit                prev_dclk = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (o_dac_clk && !prev_dclk) dac_seen.push_back(o_dac);
            if (o_underrun) uf_seen++;
            prev_dclk = o_dac_clk;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns just after the falling edge following the push.
    task automatic push_word(input logic [DATA_W-1:0] d);
        int g = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        while (!bus.o_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("push_rdy", bus.o_ready, 1);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int g = 0;
        while (o_level != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check(name, o_level, 0);
    endtask

    // First n latched values that differ from midscale must equal want[0..n-1].
    task automatic check_primed(input string name, input logic [31:0] want);
        int j = 0;
        logic [31:0] w;
        w = want;
        while (j < dac_seen.size() && dac_seen[j] == 8'h80) j++;
        for (int i = 0; i < 4; i++) begin
            if (j + i < dac_seen.size()) check(name, dac_seen[j+i], w[31-8*i -: 8]);
            else                         check(name, 32'hDEAD, w[31-8*i -: 8]);
        end
    endtask

    logic [DATA_W-1:0] sine [256];

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]        dclk_pat;
        logic [DATA_W-1:0] ctr;
        bit                r;
        bit                saw_full;
        bit                saw_back;
        int                u0;
        int                idx;
        int                stale;
`ifdef DAC_UNDERRUN_CNT_EN
        int                c0;
`endif
        for (int i = 0; i < 256; i++)
            sine[i] = 8'($rtoi(128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * (i + 64) / 256.0) + 0.5));

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        dclk_pat    = 8'b0110_0110;

        // 1. reset values, then divider running with midscale held in PRIME
        repeat (3) @(negedge clk);
        check("rst_dac",   o_dac, 8'h80);
        check("rst_dclk",  o_dac_clk, 0);
        check("rst_level", o_level, 0);
        check("rst_uflow", o_underrun, 0);
        check("rst_ready", bus.o_ready, 1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_dclk", o_dac_clk, dclk_pat[i]);
            check("idle_dac",  o_dac, 8'h80);
        end

        // 2. prime: three samples keep PRIME, the fourth starts RUN
        dac_seen.delete();
        push_word(8'h10);
        push_word(8'h20);
        push_word(8'h30);
        check("prime_dac",   o_dac, 8'h80);
        check("prime_state", o_state, PRIME);
        push_word(8'h40);
        check("run_state", o_state, RUN);
        repeat (24) @(negedge clk);
        check_primed("prime_seq", 32'h10203040);

        // 3. full: continuous valid with an incrementing payload
        dac_seen.delete();
        ctr      = 8'h60;
        saw_full = 0;
        saw_back = 0;
        repeat (120) begin
            bus.i_valid = 1'b1;
            bus.i_data  = ctr;
            r = bus.o_ready;
            if (o_level == 4'd8 && !r) saw_full = 1;
            if (saw_full && r)         saw_back = 1;
            @(posedge clk);
            if (r) ctr++;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        check("full_drop", saw_full, 1);
        check("full_back", saw_back, 1);
        idx = -1;
        for (int j = 0; j < dac_seen.size(); j++)
            if (idx < 0 && dac_seen[j] == 8'h60) idx = j;
        check("full_start", idx >= 0, 1);
        if (idx >= 0)
            for (int j = idx + 1; j < dac_seen.size(); j++)
                check("full_seq", dac_seen[j], 8'(dac_seen[j-1] + 8'd1));
        wait_empty("full_drain");

        // 4. underrun: last sample 0x55 is held and each empty tick pulses
        push_word(8'h55);
        wait_empty("uf_drain");
        repeat (2) @(negedge clk);
        u0 = uf_seen;
`ifdef DAC_UNDERRUN_CNT_EN
        c0 = int'(o_underrun_cnt);
`endif
        repeat (32) @(negedge clk);
        check("uf_pulses", uf_seen - u0, 8);
        check("uf_hold",   o_dac, 8'h55);
`ifdef DAC_UNDERRUN_CNT_EN
        check("uf_count",  int'(o_underrun_cnt) - c0, 8);
`endif

        // 5. asynchronous reset with five samples buffered
        for (int i = 0; i < 20 && o_level != 4'd5; i++) push_word(8'hA0 + 8'(i));
        check("mid_level", o_level, 5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_dac",   o_dac, 8'h80);
        check("mid_dclk",  o_dac_clk, 0);
        check("mid_level0", o_level, 0);
        check("mid_uflow", o_underrun, 0);
        check("mid_ready", bus.o_ready, 1);
        check("mid_state", o_state, PRIME);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hEE;
        repeat (3) @(negedge clk);
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        dac_seen.delete();
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        push_word(8'h04);
        repeat (24) @(negedge clk);
        check_primed("reprime_seq", 32'h01020304);
        stale = 0;
        foreach (dac_seen[j])
            if (dac_seen[j][7:4] == 4'hA || dac_seen[j] == 8'hEE) stale++;
        check("reprime_stale", stale, 0);

        // 6. steady stream: one sine sample every DAC period
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        dac_seen.delete();
        u0 = uf_seen;
        for (int i = 0; i < 1024; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = sine[i % 256];
            @(negedge clk);
            bus.i_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("stream_uflow", uf_seen - u0, 0);
        repeat (40) @(negedge clk);
        idx = 0;
        while (idx < dac_seen.size() && dac_seen[idx] == 8'h80) idx++;
        check("stream_len", (dac_seen.size() - idx) >= 1024, 1);
        if (dac_seen.size() - idx >= 1024)
            for (int i = 0; i < 1024; i++)
                check("stream_seq", dac_seen[idx+i], sine[i % 256]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_out_stage.md
# dac_out_stage

Output stage between the sine sample generator and the 8-bit video DAC used as a waveform output. It accepts samples over a valid/ready handshake and buffers them in a small FIFO. It then presents one sample per DAC period on `o_dac`, together with a generated DAC clock `o_dac_clk`. A prefill state machine and underrun detection let the upstream generator run without rate-locking to the DAC.

## Interface
- `DATA_W`, 8: sample width.
- `DEPTH`, 8: FIFO depth in samples. Must be a power of two, ≥4.
- `DIV`, 4: `i_clk` cycles per DAC period. Must be ≥2.
- `i_clk`  in  1  system clock. Single clock domain.
- `i_rst_n`  in  1  asynchronous reset, active-low.
- `i_data`  in  DATA_W  sample from upstream, offset binary.
- `i_valid`  in  1  `i_data` valid.
- `o_ready`  out  1  stage can accept a sample.
- `o_dac`  out  DATA_W  DAC data, registered.
- `o_dac_clk`  out  1  DAC sample clock, registered. The DAC latches `o_dac` on its rising edge.
- `o_underrun`  out  1  one-cycle pulse on an underrun.
- `o_level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `o_underrun_cnt`  out  16  present only under `DAC_UNDERRUN_CNT_EN`.

## Operation
- **Push:** occurs when `i_valid && o_ready` at a rising edge.
  - `o_ready = (level != DEPTH)`, combinational from the registered level.
  - A push while full is impossible by construction.
  - `i_data` is ignored while `o_ready=0`.
- **Divider:** `div_cnt` counts 0..DIV-1 and wraps. A **tick** is the edge where `div_cnt` wraps DIV-1→0.
- **FSM states:**
  - `PRIME`, entered from reset: no pops and no underrun flags. Moves to `RUN` at the first edge where `level ≥ DEPTH/2`, counting the push in that cycle.
  - `RUN`: on each tick:
    - If level>0: pop the head into `o_dac`.
    - Else: hold `o_dac` and pulse `o_underrun`.
    - `RUN` never returns to `PRIME` except through reset.
- **Push and pop in the same edge:** level is unchanged, and both data paths are correct. A push into an empty FIFO on a tick edge is not visible to that tick, which is an underrun.
- **Wrap-around:** read and write pointers are log2(DEPTH) bits and wrap naturally. Level is tracked separately and is DEPTH when full.
- **Reset (asynchronous, takes effect immediately, including mid-stream):**
  - `o_dac = 2**(DATA_W-1)` (0x80), the midscale value.
  - `o_dac_clk=0`, `o_underrun=0`, `o_level=0`.
  - `div_cnt=0`, pointers cleared, state `PRIME`, counter cleared.
  - `o_ready` reads 1 during reset; pushes are not stored while `i_rst_n=0`.

## Timing
- `o_dac` and `o_dac_clk=0` update on the same tick edge.
- `o_dac_clk` is 0 for floor(DIV/2) cycles, then 1 for the remaining cycles of the period. It rises floor(DIV/2) cycles after the data change, which gives the DAC setup time.
- Latency in `RUN` with an empty FIFO: a sample pushed at edge N appears on `o_dac` at the first tick edge after N (strictly later).
- `o_level` reflects a push or pop one edge after it.
- `o_underrun` is high for exactly the cycle after the failing tick edge.

## Configuration
- `DAC_UNDERRUN_CNT_EN` defined:
  - Adds port `o_underrun_cnt`, a 16-bit counter that increments with each `o_underrun` pulse.
  - The counter saturates at 0xFFFF and clears on reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `dac_out_pkg`: state typedef (`PRIME`, `RUN`) and the counter width constant `UNDERRUN_CNT_W = 16`.
- Sub-module `sync_fifo`, parameterized by `DATA_W` and `DEPTH`. It provides push/pop/level/full/empty and has no fall-through.
- The top level holds the divider, the FSM, the output registers and the counter.

## Test plan
All scenarios use DIV=4 and DEPTH=8.
1. **Reset:** `i_rst_n=0` → `o_dac=0x80`, `o_dac_clk=0`, `o_level=0`, `o_underrun=0`. `o_dac_clk` then toggles low 2 / high 2 cycles, with `o_dac` unchanged in `PRIME`.
2. **Prime:**
   - Push 0x10, 0x20, 0x30 → `o_dac` stays 0x80.
   - Push 0x40 → `RUN`.
   - The next ticks output 0x10, 0x20, 0x30, 0x40 in order, one per 4 cycles. Each is stable before the `o_dac_clk` rise.
3. **Full:** hold `i_valid=1` with an incrementing counter → `o_ready` drops at `o_level=8` and reasserts after a pop. The output sequence has no gaps or duplicates.
4. **Underrun:**
   - Stop feeding after 0x55 → the tick after 0x55 pulses `o_underrun` for 1 cycle and `o_dac` holds 0x55.
   - With the macro, `o_underrun_cnt` increments by 1 per empty tick.
5. **Reset mid-stream:** drop `i_rst_n` asynchronously at `o_level=5` → outputs return to reset values immediately, without waiting for a clock edge. After release the block re-primes and old samples never appear.
6. **Steady stream:** a 256-point sine fed at one sample per 4 cycles after prime → zero underruns over 4096 cycles, and the `o_dac` sequence equals the input sequence.
